riscv_mem_arbiter: RTL and testbench
====================================

# riscv_mem_arbiter

Two-port arbiter sharing the single AXI driver request/response port between the instruction-fetch (IF) and load/store (LS) requesters. It selects one requester per cycle and holds that grant until the driver accepts the request. It records the owner of every accepted request in an in-order tag FIFO and routes each returning response to that owner. It sits between the core's fetch/LSU and `riscv_axi_driver`.

## Interface
- `DEPTH`, 16: tag FIFO entries, i.e. maximum outstanding requests; power of two, at least 2.
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req_vld` in 1, `if_req_rnw` in 1, `if_req_addr` in 32, `if_req_data` in 32: IF request; 1 = read.
- `if_req_ack` out 1: IF request accepted this cycle.
- `if_rsp_vld` out 1, `if_rsp_data` out 32: IF response.
- `ls_req_vld`, `ls_req_rnw`, `ls_req_addr`, `ls_req_data`, `ls_req_ack`, `ls_rsp_vld`, `ls_rsp_data`: LS equivalents with the same widths and directions.
- `mem_req_vld` out 1, `mem_req_rnw` out 1, `mem_req_addr` out 32, `mem_req_data` out 32: to the driver.
- `mem_req_ack` in 1: driver accepts the request. Combinational in the driver.
- `mem_rsp_vld` in 1, `mem_rsp_data` in 32: driver response. Exactly one response per accepted request (read or write), in acceptance order.
- `outstanding` out $clog2(DEPTH)+1: current tag FIFO occupancy.
- `err_unexp_rsp` out 1: sticky; set by a response that arrives with the FIFO empty.

## Operation
- **States.** IDLE (no grant held) and LOCK (grant held on `lock_owner`).
- **IDLE.** Arbitrate among requesters with `*_req_vld`=1.
  - Winner's `vld/rnw/addr/data` drive `mem_req_*` combinationally, in the same cycle.
  - If `mem_req_ack`=0: go to LOCK with `lock_owner` = winner.
- **LOCK.** Only `lock_owner` is forwarded, regardless of the other requester.
  - The requester must keep its request stable until ack.
  - Return to IDLE on `mem_req_ack`=1.
  - If `lock_owner` drops `req_vld` (protocol violation), return to IDLE with no push.
- **Accept.** `*_req_ack` = `mem_req_ack` & grant & `mem_req_vld`. On accept, push the owner bit (0 = IF, 1 = LS) into the tag FIFO.
- **FIFO full.** When `outstanding`==DEPTH: `mem_req_vld`=0, no acks, and the LOCK state is retained.
- **Response routing.** On `mem_rsp_vld`: pop the head tag and assert that owner's `*_rsp_vld` with `*_rsp_data` = `mem_rsp_data`, combinationally. The other owner's `rsp_vld` stays 0.
- **Response with FIFO empty.** No pop, no `rsp_vld`, set `err_unexp_rsp`.
- **Simultaneous push and pop.** Both happen; `outstanding` is unchanged. Push while full is impossible because of gating. A pop while full permits no push in the same cycle (full gating uses the registered count).
- **Pointers.** Wrap modulo DEPTH. `outstanding` is a separate up/down counter; it must never exceed DEPTH or go below 0.
- **Idle outputs.** All `*_rsp_data` and `mem_req_addr/data/rnw` are 0 when the corresponding valid is 0.

## Timing
- **Request path.** Zero-cycle combinational from `*_req_*` to `mem_req_*`, and from `mem_req_ack` to `*_req_ack`.
- **Response path.** Zero-cycle combinational from `mem_rsp_*` to `*_rsp_*`.
- **Registered state.** Updates on the clock edge after an event: FSM state, `lock_owner`, round-robin pointer, FIFO, `outstanding`, `err_unexp_rsp`.
- **Throughput.** One accept per cycle is sustainable.
- **Reset (asserted low, asynchronous).**
  - State = IDLE; FIFO empty; `outstanding`=0; `err_unexp_rsp`=0; round-robin pointer favours LS.
  - All outputs are 0 while reset is asserted.
- **Reset mid-operation.** Outstanding tags are discarded. Responses arriving after reset release set `err_unexp_rsp`. The driver is reset concurrently.

## Configuration
- Macro `RISCV_MEM_ARB_ROUND_ROBIN_EN`.
- **Defined.** Round-robin arbitration. On an IDLE conflict, grant goes to the requester not granted last. The pointer updates on each accept to point at the other requester.
- **Undefined.** Fixed priority: LS always wins an IDLE conflict. No pointer register.

## Test plan
- **Single IF read.** IF read at addr 0x100, ack the same cycle -> `if_req_ack`=1, `outstanding`=1. Then `mem_rsp_vld` with data 0xDEADBEEF -> `if_rsp_vld`=1, `if_rsp_data`=0xDEADBEEF, `ls_rsp_vld`=0, `outstanding`=0.
- **Conflict.** IF and LS both valid, ack held high for 4 cycles.
  - Fixed priority: the LS stream goes first while LS is valid; IF waits.
  - Round-robin: grants go LS, IF, LS, IF.
- **Lock.** LS valid, ack low for 3 cycles while IF also asserts -> `mem_req_*` shows the LS request for all 3 cycles. LS acks on cycle 4; IF is not forwarded before that.
- **Full.** DEPTH=16 with 16 accepted requests and no responses -> `outstanding`=16, `mem_req_vld`=0. Next `mem_rsp_vld` -> `outstanding`=15, and an accept is allowed the following cycle.
- **Interleaved ordering.** Accept order IF, LS, LS, IF; responses 1, 2, 3, 4 -> delivered IF=1, LS=2, LS=3, IF=4. Then a simultaneous accept and response -> `outstanding` unchanged.
- **Unexpected response and reset.** `mem_rsp_vld` with the FIFO empty -> `err_unexp_rsp`=1 and stays 1. Assert `reset` low mid-stream with 5 outstanding -> `outstanding`=0 and `err_unexp_rsp`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares the single AXI driver request/response port between the instruction-fetch (IF)
// and load/store (LS) requesters.
// - A grant is held (LOCK) until the driver accepts the request.
// - The owner of each accepted request is recorded in an in-order tag FIFO.
// - Each returning response is routed to the owner at the head of that FIFO.
// Optional feature: define RISCV_MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, LS always wins an idle conflict.

module riscv_mem_arbiter #(
   parameter int DEPTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,

   input  logic                   if_req_vld,
   input  logic                   if_req_rnw,
   input  logic [31:0]            if_req_addr,
   input  logic [31:0]            if_req_data,
   output logic                   if_req_ack,
   output logic                   if_rsp_vld,
   output logic [31:0]            if_rsp_data,

   input  logic                   ls_req_vld,
   input  logic                   ls_req_rnw,
   input  logic [31:0]            ls_req_addr,
   input  logic [31:0]            ls_req_data,
   output logic                   ls_req_ack,
   output logic                   ls_rsp_vld,
   output logic [31:0]            ls_rsp_data,

   output logic                   mem_req_vld,
   output logic                   mem_req_rnw,
   output logic [31:0]            mem_req_addr,
   output logic [31:0]            mem_req_data,
   input  logic                   mem_req_ack,
   input  logic                   mem_rsp_vld,
   input  logic [31:0]            mem_rsp_data,

   output logic [$clog2(DEPTH):0] outstanding,
   output logic                   err_unexp_rsp
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   typedef enum logic {
      IDLE,
      LOCK
   } state_t;

   state_t          state;
   logic            lock_owner;
   logic            grant_vld;
   logic            grant_owner;
   logic            full;
   logic            accept;
   logic            pop;
   logic            unexp_rsp;
   logic            head_tag;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            tag_mem [DEPTH];

`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
   logic            rr_ptr;
`endif

   // Pick the requester to forward: the locked owner, otherwise arbitrate among valid requesters
   always_comb begin
      grant_vld   = 1'b0;
      grant_owner = 1'b0;
      if (state == LOCK) begin
         grant_owner = lock_owner;
         grant_vld   = lock_owner ? ls_req_vld : if_req_vld;
      end else if (if_req_vld && ls_req_vld) begin
         grant_vld   = 1'b1;
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
         grant_owner = rr_ptr;
`else
         grant_owner = 1'b1;
`endif
      end else if (ls_req_vld) begin
         grant_vld   = 1'b1;
         grant_owner = 1'b1;
      end else if (if_req_vld) begin
         grant_vld   = 1'b1;
         grant_owner = 1'b0;
      end
   end

   // A full FIFO blocks forwarding; reset forces every request-side output low
   assign full         = (count == FULL_COUNT);
   assign mem_req_vld  = reset & grant_vld & ~full;
   assign mem_req_rnw  = mem_req_vld & (grant_owner ? ls_req_rnw : if_req_rnw);
   assign mem_req_addr = mem_req_vld ? (grant_owner ? ls_req_addr : if_req_addr) : 32'h0;
   assign mem_req_data = mem_req_vld ? (grant_owner ? ls_req_data : if_req_data) : 32'h0;

   assign accept     = mem_req_vld & mem_req_ack;
   assign if_req_ack = accept & ~grant_owner;
   assign ls_req_ack = accept & grant_owner;

   // A response with no tag recorded is flagged instead of popping
   assign pop       = mem_rsp_vld & (count != '0);
   assign unexp_rsp = mem_rsp_vld & (count == '0);
   assign head_tag  = tag_mem[rd_ptr];

   assign if_rsp_vld  = pop & ~head_tag;
   assign ls_rsp_vld  = pop & head_tag;
   assign if_rsp_data = if_rsp_vld ? mem_rsp_data : 32'h0;
   assign ls_rsp_data = ls_rsp_vld ? mem_rsp_data : 32'h0;

   assign outstanding = count;

   // Grant FSM: hold the winner until the driver accepts it or the owner withdraws
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         lock_owner <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld && !accept) begin
                  state      <= LOCK;
                  lock_owner <= grant_owner;
               end
            end
            LOCK: begin
               if (!grant_vld || accept) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
   // Round-robin pointer: after each accept, favour the requester that was not served
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr <= 1'b1;
      end else if (accept) begin
         rr_ptr <= ~grant_owner;
      end
   end
`endif

   // Tag storage: record the owner of each accepted request (contents need no reset)
   always_ff @(posedge clock) begin
      if (accept) begin
         tag_mem[wr_ptr] <= grant_owner;
      end
   end

   // FIFO pointers and occupancy counter; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flag for responses that arrive with nothing outstanding
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_unexp_rsp <= 1'b0;
      end else if (unexp_rsp) begin
         err_unexp_rsp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter
// Directed-vector bench for riscv_mem_arbiter with DEPTH=16.
// Expected results follow RISCV_MEM_ARB_ROUND_ROBIN_EN when that macro is defined.

module tb_riscv_mem_arbiter;

   localparam logic L = 1'b0;
   localparam logic H = 1'b1;

   logic        clock;
   logic        reset;
   logic        if_req_vld, if_req_rnw, if_req_ack, if_rsp_vld;
   logic [31:0] if_req_addr, if_req_data, if_rsp_data;
   logic        ls_req_vld, ls_req_rnw, ls_req_ack, ls_rsp_vld;
   logic [31:0] ls_req_addr, ls_req_data, ls_rsp_data;
   logic        mem_req_vld, mem_req_rnw, mem_req_ack, mem_rsp_vld;
   logic [31:0] mem_req_addr, mem_req_data, mem_rsp_data;
   logic [4:0]  outstanding;
   logic        err_unexp_rsp;

   int n_compared   = 0;
   int n_mismatched = 0;

   typedef struct {
      logic        if_vld;
      logic        if_rnw;
      logic [31:0] if_addr;
      logic [31:0] if_data;
      logic        ls_vld;
      logic        ls_rnw;
      logic [31:0] ls_addr;
      logic [31:0] ls_data;
      logic        ack;
      logic        rsp_vld;
      logic [31:0] rsp_data;
      logic        x_mem_vld;
      logic        x_mem_rnw;
      logic [31:0] x_mem_addr;
      logic [31:0] x_mem_data;
      logic        x_if_ack;
      logic        x_ls_ack;
      logic        x_if_rsp;
      logic        x_ls_rsp;
      logic [31:0] x_rsp_data;
      logic [4:0]  x_out;
   } vec_t;

   vec_t vectors [15];

   riscv_mem_arbiter #(.DEPTH(16)) dut (
      .clock         (clock),
      .reset         (reset),
      .if_req_vld    (if_req_vld),
      .if_req_rnw    (if_req_rnw),
      .if_req_addr   (if_req_addr),
      .if_req_data   (if_req_data),
      .if_req_ack    (if_req_ack),
      .if_rsp_vld    (if_rsp_vld),
      .if_rsp_data   (if_rsp_data),
      .ls_req_vld    (ls_req_vld),
      .ls_req_rnw    (ls_req_rnw),
      .ls_req_addr   (ls_req_addr),
      .ls_req_data   (ls_req_data),
      .ls_req_ack    (ls_req_ack),
      .ls_rsp_vld    (ls_rsp_vld),
      .ls_rsp_data   (ls_rsp_data),
      .mem_req_vld   (mem_req_vld),
      .mem_req_rnw   (mem_req_rnw),
      .mem_req_addr  (mem_req_addr),
      .mem_req_data  (mem_req_data),
      .mem_req_ack   (mem_req_ack),
      .mem_rsp_vld   (mem_rsp_vld),
      .mem_rsp_data  (mem_rsp_data),
      .outstanding   (outstanding),
      .err_unexp_rsp (err_unexp_rsp)
   );

   // Free-running clock, 10 time units per cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(
      input logic ifv, input logic ifr, input logic [31:0] ifa, input logic [31:0] ifd,
      input logic lsv, input logic lsr, input logic [31:0] lsa, input logic [31:0] lsd,
      input logic ack, input logic rv, input logic [31:0] rd,
      input logic xmv, input logic xmr, input logic [31:0] xma, input logic [31:0] xmd,
      input logic xia, input logic xla, input logic xir, input logic xlr,
      input logic [31:0] xrd, input logic [4:0] xout);
      vec_t v;
      v.if_vld = ifv; v.if_rnw = ifr; v.if_addr = ifa; v.if_data = ifd;
      v.ls_vld = lsv; v.ls_rnw = lsr; v.ls_addr = lsa; v.ls_data = lsd;
      v.ack = ack; v.rsp_vld = rv; v.rsp_data = rd;
      v.x_mem_vld = xmv; v.x_mem_rnw = xmr; v.x_mem_addr = xma; v.x_mem_data = xmd;
      v.x_if_ack = xia; v.x_ls_ack = xla; v.x_if_rsp = xir; v.x_ls_rsp = xlr;
      v.x_rsp_data = xrd; v.x_out = xout;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      if_req_vld   = v.if_vld;
      if_req_rnw   = v.if_rnw;
      if_req_addr  = v.if_addr;
      if_req_data  = v.if_data;
      ls_req_vld   = v.ls_vld;
      ls_req_rnw   = v.ls_rnw;
      ls_req_addr  = v.ls_addr;
      ls_req_data  = v.ls_data;
      mem_req_ack  = v.ack;
      mem_rsp_vld  = v.rsp_vld;
      mem_rsp_data = v.rsp_data;
   endtask

   // One cycle: drive after the falling edge, check combinational paths, then the count after the rise
   task automatic runVector(input vec_t v, input string tag);
      @(negedge clock);
      applyStimulus(v);
      #2;
      checkOutput({tag, ".mem_req_vld"},  32'(mem_req_vld),  32'(v.x_mem_vld));
      checkOutput({tag, ".mem_req_rnw"},  32'(mem_req_rnw),  32'(v.x_mem_rnw));
      checkOutput({tag, ".mem_req_addr"}, mem_req_addr,      v.x_mem_addr);
      checkOutput({tag, ".mem_req_data"}, mem_req_data,      v.x_mem_data);
      checkOutput({tag, ".if_req_ack"},   32'(if_req_ack),   32'(v.x_if_ack));
      checkOutput({tag, ".ls_req_ack"},   32'(ls_req_ack),   32'(v.x_ls_ack));
      checkOutput({tag, ".if_rsp_vld"},   32'(if_rsp_vld),   32'(v.x_if_rsp));
      checkOutput({tag, ".ls_rsp_vld"},   32'(ls_rsp_vld),   32'(v.x_ls_rsp));
      checkOutput({tag, ".if_rsp_data"},  if_rsp_data,       v.x_if_rsp ? v.x_rsp_data : 32'h0);
      checkOutput({tag, ".ls_rsp_data"},  ls_rsp_data,       v.x_ls_rsp ? v.x_rsp_data : 32'h0);
      @(posedge clock);
      #1;
      checkOutput({tag, ".outstanding"},  32'(outstanding),  32'(v.x_out));
   endtask

   vec_t idle_v;
   logic ls_turn;

   initial begin
      idle_v = mk(L,L,0,0, L,L,0,0, L,L,0, L,L,0,0, L,L,L,L,0, 5'd0);

      // Basic traffic from reset: single read, ordered responses, simultaneous push/pop, lock
      vectors[0]  = mk(L,L,0,0,                  L,L,0,0,                  L,L,0,            L,L,0,0,                  L,L,L,L,0,            5'd0);
      vectors[1]  = mk(H,H,'h100,0,              L,L,0,0,                  H,L,0,            H,H,'h100,0,              H,L,L,L,0,            5'd1);
      vectors[2]  = mk(L,L,0,0,                  L,L,0,0,                  L,H,'hDEADBEEF,   L,L,0,0,                  L,L,H,L,'hDEADBEEF,   5'd0);
      vectors[3]  = mk(H,L,'h200,'h11111111,     L,L,0,0,                  H,L,0,            H,L,'h200,'h11111111,     H,L,L,L,0,            5'd1);
      vectors[4]  = mk(L,L,0,0,                  H,H,'h300,0,              H,L,0,            H,H,'h300,0,              L,H,L,L,0,            5'd2);
      vectors[5]  = mk(L,L,0,0,                  H,L,'h304,'h22222222,     H,L,0,            H,L,'h304,'h22222222,     L,H,L,L,0,            5'd3);
      vectors[6]  = mk(H,H,'h104,0,              L,L,0,0,                  H,L,0,            H,H,'h104,0,              H,L,L,L,0,            5'd4);
      vectors[7]  = mk(L,L,0,0,                  L,L,0,0,                  L,H,1,            L,L,0,0,                  L,L,H,L,1,            5'd3);
      vectors[8]  = mk(L,L,0,0,                  L,L,0,0,                  L,H,2,            L,L,0,0,                  L,L,L,H,2,            5'd2);
      vectors[9]  = mk(L,L,0,0,                  L,L,0,0,                  L,H,3,            L,L,0,0,                  L,L,L,H,3,            5'd1);
      vectors[10] = mk(L,L,0,0,                  H,H,'h308,0,              H,H,4,            H,H,'h308,0,              L,H,H,L,4,            5'd1);
      vectors[11] = mk(L,L,0,0,                  L,L,0,0,                  L,H,5,            L,L,0,0,                  L,L,L,H,5,            5'd0);
      vectors[12] = mk(H,H,'h400,0,              L,L,0,0,                  L,L,0,            H,H,'h400,0,              L,L,L,L,0,            5'd0);
      vectors[13] = mk(H,H,'h400,0,              H,L,'h500,'h55,           H,L,0,            H,H,'h400,0,              H,L,L,L,0,            5'd1);
      vectors[14] = mk(L,L,0,0,                  L,L,0,0,                  L,H,6,            L,L,0,0,                  L,L,H,L,6,            5'd0);

      // Reset asserted with a request pending: every output must be low
      reset = 1'b0;
      applyStimulus(mk(H,H,'h100,'h5, H,L,'h200,'h6, H,H,'h7, L,L,0,0, L,L,L,L,0, 5'd0));
      #3;
      checkOutput("reset.mem_req_vld",   32'(mem_req_vld),   32'd0);
      checkOutput("reset.mem_req_addr",  mem_req_addr,       32'd0);
      checkOutput("reset.if_req_ack",    32'(if_req_ack),    32'd0);
      checkOutput("reset.ls_req_ack",    32'(ls_req_ack),    32'd0);
      checkOutput("reset.if_rsp_vld",    32'(if_rsp_vld),    32'd0);
      checkOutput("reset.outstanding",   32'(outstanding),   32'd0);
      checkOutput("reset.err_unexp_rsp", 32'(err_unexp_rsp), 32'd0);
      applyStimulus(idle_v);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      $display("[TB] table vectors");
      for (int i = 0; i < 15; i++) begin
         runVector(vectors[i], $sformatf("vec%0d", i));
      end
      checkOutput("table.err_unexp_rsp", 32'(err_unexp_rsp), 32'd0);

      // Conflict with ack held high for four cycles
      $display("[TB] conflict sequence");
      for (int i = 0; i < 4; i++) begin
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
         ls_turn = (i % 2 == 0);
`else
         ls_turn = 1'b1;
`endif
         if (ls_turn)
            runVector(mk(H,H,'h800,0, H,L,'h900,'h99, H,L,0, H,L,'h900,'h99, L,H,L,L,0, 5'(i+1)), $sformatf("conflict%0d", i));
         else
            runVector(mk(H,H,'h800,0, H,L,'h900,'h99, H,L,0, H,H,'h800,0,    H,L,L,L,0, 5'(i+1)), $sformatf("conflict%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
         ls_turn = (i % 2 == 0);
`else
         ls_turn = 1'b1;
`endif
         runVector(mk(L,L,0,0, L,L,0,0, L,H,32'hA0 + 32'(i), L,L,0,0, L,L,~ls_turn,ls_turn,32'hA0 + 32'(i), 5'(3-i)), $sformatf("conflict_rsp%0d", i));
      end

      // Lock: LS stalled three cycles while IF also requests, then accepted
      $display("[TB] lock sequence");
      for (int i = 0; i < 3; i++) begin
         runVector(mk(H,H,'h700,0, H,H,'h600,0, L,L,0, H,H,'h600,0, L,L,L,L,0, 5'd0), $sformatf("lock%0d", i));
      end
      runVector(mk(H,H,'h700,0, H,H,'h600,0, H,L,0, H,H,'h600,0, L,H,L,L,0, 5'd1), "lock3");
      runVector(mk(L,L,0,0, L,L,0,0, L,H,'h77, L,L,0,0, L,L,L,H,'h77, 5'd0), "lock_rsp");

      // Full: sixteen accepts, blocked request, pop frees one slot for the next cycle
      $display("[TB] full sequence");
      for (int i = 0; i < 16; i++) begin
         runVector(mk(H,H,32'h1000 + 32'(4*i),0, L,L,0,0, H,L,0, H,H,32'h1000 + 32'(4*i),0, H,L,L,L,0, 5'(i+1)), $sformatf("fill%0d", i));
      end
      runVector(mk(H,H,'h2000,0, L,L,0,0, H,L,0,     L,L,0,0,       L,L,L,L,0,     5'd16), "full_block");
      runVector(mk(H,H,'h2000,0, L,L,0,0, H,H,'hF0,  L,L,0,0,       L,L,H,L,'hF0,  5'd15), "full_pop");
      runVector(mk(H,H,'h2000,0, L,L,0,0, H,L,0,     H,H,'h2000,0,  H,L,L,L,0,     5'd16), "full_refill");
      for (int i = 0; i < 16; i++) begin
         runVector(mk(L,L,0,0, L,L,0,0, L,H,32'(i), L,L,0,0, L,L,H,L,32'(i), 5'(15-i)), $sformatf("drain%0d", i));
      end

      // Unexpected response sets the sticky error
      $display("[TB] unexpected response");
      runVector(mk(L,L,0,0, L,L,0,0, L,H,'hBAD, L,L,0,0, L,L,L,L,0, 5'd0), "unexp");
      checkOutput("unexp.err_set", 32'(err_unexp_rsp), 32'd1);
      runVector(idle_v, "unexp_hold");
      checkOutput("unexp.err_sticky", 32'(err_unexp_rsp), 32'd1);

      // Asynchronous reset with five outstanding requests
      $display("[TB] reset mid-stream");
      for (int i = 0; i < 5; i++) begin
         runVector(mk(H,H,32'h3000 + 32'(4*i),0, L,L,0,0, H,L,0, H,H,32'h3000 + 32'(4*i),0, H,L,L,L,0, 5'(i+1)), $sformatf("pre_reset%0d", i));
      end
      @(negedge clock);
      applyStimulus(mk(H,H,'h3100,0, L,L,0,0, H,L,0, L,L,0,0, L,L,L,L,0, 5'd0));
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset.outstanding",   32'(outstanding),   32'd0);
      checkOutput("async_reset.err_unexp_rsp", 32'(err_unexp_rsp), 32'd0);
      checkOutput("async_reset.mem_req_vld",   32'(mem_req_vld),   32'd0);
      checkOutput("async_reset.if_req_ack",    32'(if_req_ack),    32'd0);
      applyStimulus(idle_v);
      @(negedge clock);
      reset = 1'b1;
      runVector(mk(L,L,0,0, L,L,0,0, L,H,'h5A, L,L,0,0, L,L,L,L,0, 5'd0), "post_reset_rsp");
      checkOutput("post_reset.err_unexp_rsp", 32'(err_unexp_rsp), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
